// File: rtl/spell_trace_ctrl.sv
// rtl/spell_trace_ctrl.sv - debounced 4x4 IR grid tracer checked against a latched spell sequence
module spell_trace_ctrl #(
   parameter int DEBOUNCE = 50000,
   parameter int TIMEOUT  = 250000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir_raw,
   input  logic        start,
   input  logic [31:0] target_seq,
   input  logic [3:0]  target_len,
   output logic [15:0] traced_mask,
   output logic [3:0]  step,
   output logic        busy,
   output logic        done,
   output logic        success,
   output logic        fail,
   output logic [1:0]  fail_code
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_TRACING = 3'd2,
      ST_SUCCESS = 3'd3,
      ST_FAIL    = 3'd4
   } state_t;

   state_t        state;
   logic [15:0]   ir_m;
   logic [15:0]   ir_s;
   logic          sel_valid;
   logic [3:0]    sel_idx;
   logic [3:0]    prev_idx;
   logic [DW-1:0] dwell_cnt;
   logic [DW-1:0] dwell_nxt;
   logic          same_box;
   logic          hit;
   logic [TW-1:0] to_cnt;
   logic          to_hit;
   logic [31:0]   tgt_seq;
   logic [3:0]    tgt_len;
   logic [3:0]    tgt_nib;
   logic          idx_ok;
   logic [3:0]    step_nxt;

   // Lowest set box wins when several sensors see the wand at once.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (ir_s[i]) begin
            sel_valid = 1'b1;
            sel_idx   = 4'(i);
         end
      end
   end

   // A non-zero dwell count means the previous cycle had a valid selection.
   assign same_box = (dwell_cnt != '0) && (sel_idx == prev_idx);

   always_comb begin
      dwell_nxt = '0;
      if (sel_valid) begin
         if (!same_box)
            dwell_nxt = DW'(1);
         else if (dwell_cnt != DW'(DEBOUNCE))
            dwell_nxt = dwell_cnt + DW'(1);
         else
            dwell_nxt = dwell_cnt;
      end
   end

   // Fires only on the transition into saturation, so one hit per dwell.
   assign hit = (dwell_nxt == DW'(DEBOUNCE)) && !(same_box && (dwell_cnt == DW'(DEBOUNCE)));

   assign to_hit   = (to_cnt == TW'(TIMEOUT - 1));
   assign tgt_nib  = tgt_seq[{step[2:0], 2'b00} +: 4];
   assign idx_ok   = (sel_idx == tgt_nib);
   assign step_nxt = step + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         ir_m        <= '0;
         ir_s        <= '0;
         prev_idx    <= '0;
         dwell_cnt   <= '0;
         to_cnt      <= '0;
         tgt_seq     <= '0;
         tgt_len     <= '0;
         traced_mask <= '0;
         step        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         success     <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= 2'b00;
      end else begin
         ir_m      <= ir_raw;
         ir_s      <= ir_m;
         prev_idx  <= sel_idx;
         dwell_cnt <= dwell_nxt;
         done      <= 1'b0;

         if (start) begin
            tgt_seq     <= target_seq;
            tgt_len     <= target_len;
            traced_mask <= '0;
            step        <= '0;
            to_cnt      <= '0;
            success     <= 1'b0;
            if (target_len == 4'd0 || target_len > 4'd8) begin
               state     <= ST_FAIL;
               busy      <= 1'b0;
               fail      <= 1'b1;
               done      <= 1'b1;
               fail_code <= 2'b11;
            end else begin
               state     <= ST_ARMED;
               busy      <= 1'b1;
               fail      <= 1'b0;
               fail_code <= 2'b00;
            end
         end else begin
            case (state)
               ST_ARMED, ST_TRACING: begin
                  if (hit && idx_ok) begin
                     traced_mask <= traced_mask | (16'd1 << sel_idx);
                     step        <= step_nxt;
                     to_cnt      <= '0;
                     if (step_nxt == tgt_len) begin
                        state   <= ST_SUCCESS;
                        busy    <= 1'b0;
                        success <= 1'b1;
                        done    <= 1'b1;
                     end else begin
                        state <= ST_TRACING;
                     end
                  end else if (hit) begin
                     state     <= ST_FAIL;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     fail_code <= 2'b01;
                  end else if (state == ST_TRACING) begin
                     if (to_hit) begin
                        state     <= ST_FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        done      <= 1'b1;
                        fail_code <= 2'b10;
                     end else begin
                        to_cnt <= to_cnt + TW'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spell_trace_ctrl.sv
// tb/tb_spell_trace_ctrl.sv - randomized and directed bench for spell_trace_ctrl against a spell-rule model
module tb_spell_trace_ctrl;

   localparam int DB = 4;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] ir_raw = '0;
   logic        start = 1'b0;
   logic [31:0] target_seq = '0;
   logic [3:0]  target_len = '0;
   logic [15:0] traced_mask;
   logic [3:0]  step;
   logic        busy, done, success, fail;
   logic [1:0]  fail_code;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   spell_trace_ctrl #(.DEBOUNCE(DB), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ir_raw(ir_raw), .start(start),
      .target_seq(target_seq), .target_len(target_len),
      .traced_mask(traced_mask), .step(step), .busy(busy), .done(done),
      .success(success), .fail(fail), .fail_code(fail_code)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: sensor history, run length of one box, and spell progress.
   localparam int M_IDLE = 0, M_ARM = 1, M_TRC = 2, M_OK = 3, M_BAD = 4;
   logic [15:0] m_m, m_s, m_mask;
   logic [31:0] m_seq;
   int m_len, m_state, m_step, m_code, m_since, run, last, idx;
   bit m_done, m_hit;

   function automatic int lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_m = '0; m_s = '0; m_mask = '0; m_seq = '0;
         m_len = 0; m_state = M_IDLE; m_step = 0; m_code = 0; m_since = 0;
         run = 0; last = -1; m_done = 0;
      end else begin
         idx = lowest(m_s);
         if (idx < 0) run = 0;
         else if (run > 0 && idx == last) run++;
         else run = 1;
         last = idx;
         m_hit = (run == DB);
         m_s = m_m;
         m_m = ir_raw;
         m_done = 0;
         if (start) begin
            m_seq = target_seq; m_len = int'(target_len);
            m_mask = '0; m_step = 0; m_code = 0; m_since = 0;
            if (m_len == 0 || m_len > 8) begin
               m_state = M_BAD; m_code = 3; m_done = 1;
            end else m_state = M_ARM;
         end else if (m_state == M_ARM || m_state == M_TRC) begin
            if (m_hit) begin
               if (idx == int'((m_seq >> (4 * m_step)) & 32'hF)) begin
                  m_mask[idx] = 1'b1;
                  m_step++;
                  m_since = 0;
                  if (m_step == m_len) begin m_state = M_OK; m_done = 1; end
                  else m_state = M_TRC;
               end else begin
                  m_state = M_BAD; m_code = 1; m_done = 1;
               end
            end else if (m_state == M_TRC) begin
               m_since++;
               if (m_since == TO) begin m_state = M_BAD; m_code = 2; m_done = 1; end
            end
         end
      end
   end

   function automatic logic [31:0] got_vec();
      return {6'd0, traced_mask, step, busy, done, success, fail, fail_code};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {6'd0, m_mask, 4'(m_step), 1'(m_state == M_ARM || m_state == M_TRC), 1'(m_done),
              1'(m_state == M_OK), 1'(m_state == M_BAD), 2'(m_code)};
   endfunction

   always @(negedge clk) begin
      chk("cycle", got_vec(), exp_vec());
      if (done) n_done++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input logic [31:0] seq, input logic [3:0] len);
      start = 1'b1; target_seq = seq; target_len = len;
      tick(1);
      start = 1'b0; target_seq = $urandom; target_len = 4'($urandom);
   endtask

   task automatic hold(input logic [15:0] v, input int n, input int gap);
      ir_raw = v; tick(n);
      ir_raw = '0; tick(gap);
   endtask

   int d0, nxt;
   logic [15:0] v;

   initial begin
      tick(2);
      chk("rst_state", got_vec(), 32'd0);
      reset = 1'b0;
      tick(2);

      // Happy path with latency probe on the first box.
      do_start(32'h0000_0A50, 4'd3);
      d0 = n_done;
      ir_raw = 16'h0001; tick(5);
      chk("lat_before", 32'(traced_mask), 32'h0000);
      tick(1);
      chk("lat_after", 32'(traced_mask), 32'h0001);
      chk("lat_step", 32'(step), 32'd1);
      tick(4); ir_raw = '0; tick(3);
      hold(16'h0020, 10, 3);
      chk("happy_mask2", 32'(traced_mask), 32'h0021);
      hold(16'h0400, 10, 3);
      chk("happy_mask3", 32'(traced_mask), 32'h0421);
      chk("happy_step", 32'(step), 32'd3);
      chk("happy_succ", 32'(success), 32'd1);
      chk("happy_done", 32'(n_done - d0), 32'd1);

      // Bounce rejection.
      do_start(32'h0000_0007, 4'd1);
      repeat (5) hold(16'h0080, 3, 1);
      chk("bounce_mask", 32'(traced_mask), 32'h0000);
      chk("bounce_busy", 32'(busy), 32'd1);
      ir_raw = 16'h0080; tick(6);
      chk("bounce_hold", 32'(traced_mask), 32'h0080);
      chk("bounce_succ", 32'(success), 32'd1);
      ir_raw = '0; tick(3);

      // Wrong box.
      do_start(32'h0000_0050, 4'd2);
      hold(16'h0001, 10, 3);
      hold(16'h0040, 10, 3);
      chk("wrong_fail", 32'({fail, fail_code}), 32'b101);
      chk("wrong_mask", 32'({traced_mask, step}), {12'd0, 16'h0001, 4'd1});

      // Timeout after one step.
      do_start(32'h0000_0050, 4'd2);
      ir_raw = 16'h0001; tick(6); ir_raw = '0;
      tick(99);
      chk("to_early", 32'(fail), 32'd0);
      tick(1);
      chk("to_fail", 32'({fail, fail_code}), 32'b110);
      tick(3);

      // Hit landing exactly on the timeout edge wins.
      do_start(32'h0000_0050, 4'd2);
      ir_raw = 16'h0001; tick(6); ir_raw = '0;
      tick(94);
      ir_raw = 16'h0020; tick(6);
      chk("race_succ", 32'({success, fail}), 32'b10);
      chk("race_step", 32'(step), 32'd2);
      ir_raw = '0; tick(3);

      // Priority encoder and repeated target indices.
      do_start(32'h0000_0003, 4'd1);
      hold(16'h0208, 6, 3);
      chk("prio_mask", 32'(traced_mask), 32'h0008);
      do_start(32'h0000_0044, 4'd2);
      hold(16'h0010, 20, 2);
      chk("repeat_hold", 32'({step, busy}), {4'd1, 1'b1});
      hold(16'h0010, 6, 2);
      chk("repeat_back", 32'({traced_mask, step, success}), {16'h0010, 4'd2, 1'b1});

      // Bad length start.
      do_start(32'h0000_0000, 4'd0);
      chk("len0", 32'({fail, done, fail_code}), 32'b1111);
      tick(1);
      chk("len0_done", 32'(done), 32'd0);
      do_start(32'h0000_0000, 4'd9);
      chk("len9", 32'(fail_code), 32'd3);

      // Restart mid-trace.
      do_start(32'h0000_0050, 4'd2);
      ir_raw = 16'h0001; tick(6); ir_raw = '0;
      do_start(32'h0000_0050, 4'd2);
      chk("restart", 32'({traced_mask, step, busy, fail}), {16'h0000, 4'd0, 2'b10});

      // Asynchronous reset in the middle of a dwell.
      ir_raw = 16'h0001; tick(6);
      ir_raw = 16'h0020; tick(2);
      #2 reset = 1'b1;
      #1 chk("async_rst", got_vec(), 32'd0);
      ir_raw = '0;
      tick(2);
      reset = 1'b0;
      tick(2);

      // Randomized traces, mostly following the spell, with jumps, bursts and idles.
      for (int it = 0; it < 40; it++) begin
         do_start($urandom, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8)));
         for (int s = 0; s < 10; s++) begin
            nxt = int'((m_seq >> (4 * (m_step & 7))) & 32'hF);
            v = 16'd1 << (($urandom_range(0, 9) < 7) ? nxt : $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) v = v | 16'($urandom);
            hold(v, $urandom_range(1, 8), $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) tick($urandom_range(90, 110));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spell_trace_ctrl.md
# spell_trace_ctrl

Sequencing controller for the 4x4 wand-tracing grid. It debounces the raw 16-bit IR sensor vector and checks the boxes the player visits against a latched target spell sequence. It accumulates correctly traced boxes into `traced_mask`, which drives the grid renderer's `ir_in`, and reports success, failure and timeout to the game FSM. It sits between the IR sensor pins and the 4x4 grid display block.

## Interface

- `DEBOUNCE`, default 50000: consecutive synchronized cycles a box must stay selected to count as a hit (≥1).
- `TIMEOUT`, default 250000000: maximum cycles between accepted hits while tracing (≥1).
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `ir_raw`, in, 16: raw IR sensor bits. Bit n is box n: row = n/4, col = n%4.
- `start`, in, 1: single-cycle pulse; latches the target and begins a new trace.
- `target_seq`, in, 32: eight 4-bit box indices; step 0 is `[3:0]`, step 7 is `[31:28]`.
- `target_len`, in, 4: number of valid steps, 1..8.
- `traced_mask`, out, 16: boxes correctly traced so far; drives the grid's `ir_in`.
- `step`, out, 4: number of steps matched so far.
- `busy`, out, 1: high in ARMED or TRACING.
- `done`, out, 1: one-cycle pulse on entry to SUCCESS or FAIL.
- `success`, out, 1: level; high while in SUCCESS.
- `fail`, out, 1: level; high while in FAIL.
- `fail_code`, out, 2: cause of failure. 00 none, 01 wrong box, 10 timeout, 11 bad length.

## Operation

- **Input path.** `ir_raw` passes a 2-flop synchronizer (`ir_s`). A priority encoder selects the lowest set index of `ir_s`, giving `sel_valid` and `sel_idx`.
- **Dwell counter.** `dwell_cnt` (width of `DEBOUNCE`) counts the following way:
  - Cleared when `sel_valid`=0 or `sel_idx` differs from the previous cycle's index.
  - Otherwise increments, saturating at `DEBOUNCE`.
  - A hit fires exactly once per dwell, on the cycle `dwell_cnt` reaches `DEBOUNCE`.
  - Re-hitting the same box requires leaving it; a direct jump A→B with no gap starts a new dwell for B.
- **States:** IDLE, ARMED, TRACING, SUCCESS, FAIL.
- **`start`, any state.** Latch `target_seq`/`target_len`, clear `traced_mask`, `step`, `fail_code` and the timeout counter.
  - Go to ARMED, or to FAIL with code 11 if `target_len` is 0 or >8.
  - `start` has priority over a simultaneous hit or timeout.
- **ARMED.** No timeout.
  - Hit with index == `tgt[0]`: set the mask bit, step=1, go to TRACING. If len==1, go to SUCCESS instead.
  - Hit on any other index: go to FAIL, code 01.
- **TRACING.** The timeout counter increments every cycle and clears on each accepted hit.
  - Hit with index == `tgt[step]`: set the mask bit, step+1. If the new step == len, go to SUCCESS.
  - Hit on a wrong index: go to FAIL, code 01.
  - Counter reaching `TIMEOUT`: go to FAIL, code 10.
  - Hit and timeout in the same cycle: the hit wins.
- **Repeated indices in the target.** Allowed; the mask bit simply stays set.
- **SUCCESS / FAIL.** Hold `traced_mask`, `step` and `fail_code`; ignore hits. Leave only on `start` or `reset`.
- **IDLE.** Hits are ignored.
- **Mid-operation changes.** Changing `target_seq`/`target_len` mid-trace has no effect; only the latched copy is used.

## Timing

- **Reset** (asynchronous, any time, including mid-trace):
  - State IDLE.
  - `traced_mask`, `step`, `busy`, `done`, `success`, `fail`, `fail_code` all 0.
  - Synchronizer, dwell counter and timeout counter cleared.
- **Registered outputs.** All outputs are registered and update on the clock edge of the transition that causes them.
- **Hit latency.** `ir_raw` is held from before edge E. The `traced_mask` bit and `step` update at edge E+DEBOUNCE+1, visible after that edge, i.e. DEBOUNCE+2 cycles of latency. `done` pulses in that same cycle when the hit completes the trace.
- **`start` latency.** `start` sampled at edge E: `busy`=1 after E. For a bad length, `fail`=1, `done`=1 and `fail_code`=11 after E.
- **Timeout.** `fail` asserts TIMEOUT cycles after the last accepted hit's edge.
- **`done` width.** Exactly one cycle per terminal entry, including entry on `start` with a bad length.

## Test plan

Benches use DEBOUNCE=4 and TIMEOUT=100.

- **Happy path.** Reset, then start with len=3 and seq 0,5,10. Hold each box 10 cycles with 3-cycle gaps.
  - Required: `traced_mask` goes 0x0001 → 0x0021 → 0x0421.
  - `step` goes 1 → 2 → 3; `success`=1 with a single `done` pulse; each update is 6 cycles after the raw rise.
- **Bounce rejection.** Start with len=1 and seq 7. Toggle `ir_raw[7]` 3 cycles high / 1 low five times.
  - Required: no change.
  - Then hold it 6 cycles: `traced_mask`=0x0080, `success`=1.
- **Wrong box.** Seq 0,5. Trace box 0, then hold box 6.
  - Required: `fail`=1, `fail_code`=01, `traced_mask`=0x0001, `step`=1.
- **Timeout and hit race.**
  - Trace one step, then idle 100 cycles: `fail_code`=10.
  - Repeat with the next hit landing on the timeout cycle: the hit is accepted.
- **Priority and repeats.**
  - Hold boxes 3 and 9 together: index 3 is chosen.
  - Seq 4,4: requires leave-and-return; holding box 4 continuously yields step=1 only.
- **Start and reset edge cases.**
  - `start` with len=0: `fail_code`=11 after one edge.
  - `start` mid-TRACING: mask cleared, ARMED.
  - `reset` mid-dwell: all outputs 0 immediately, asynchronously.
